udp_rx_check: RTL and testbench
===============================

Name: udp_rx_check

Overview:
- Sink and checker for the bring-up byte stream (sof/vld/data/eof with ready back-pressure).
- Consumes frames from the fixed-payload source over the same interface.
- Checks each frame for the incrementing payload 0x00,0x01,… and for length EXP_LEN.
- Keeps saturating good/bad frame counters and sticky error flags for bring-up status registers.

Parameters:
- EXP_LEN, 32: expected payload bytes per frame (1..255).
- TIMEOUT_CYC, 1024: maximum cycles from sof to eof before the frame is abandoned (fits 16 bits).
- THR_MASK, 7: throttle period mask; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- enable  in  1  allow ready assertion
- clear  in  1  synchronous clear of counters, flags and last_len
- sof  in  1  start-of-frame pulse (precedes or coincides with the first beat)
- vld  in  1  data beat valid
- data  in  8  payload byte
- eof  in  1  last beat marker, qualified by vld
- ready  out  1  sink may accept beats; source reacts one cycle later
- busy  out  1  high in RECV or DISCARD
- frame_ok  out  1  one-cycle pulse: good frame completed
- frame_err  out  1  one-cycle pulse: bad frame completed or abandoned
- ok_cnt  out  16  good frames, saturating at 0xFFFF
- err_cnt  out  16  bad frames, saturating at 0xFFFF
- err_flags  out  5  sticky flags: [0] seq, [1] len, [2] sof-in-frame, [3] orphan beat, [4] timeout
- last_len  out  8  beat count of the most recently closed frame

Behaviour:
- Clocking and reset: single clock clk; asynchronous active-low reset rst_n. All outputs reset to 0.
- Output timing: all outputs registered.
- Acceptance:
  - Every vld beat is accepted, whatever the state of ready. The source launches a beat the cycle after it sampled ready, so a beat may follow ready deassertion by one cycle.
  - ready = enable (feature off).
- States: IDLE, RECV, DISCARD. Internal 8-bit idx, frame-bad bit, 16-bit timer.
- IDLE:
  - sof → RECV, idx=0, bad=0, timer=0.
  - If vld arrives in the same cycle as sof, it is beat 0 and is processed as in RECV.
  - vld without sof → set flag[3]; beat dropped; counters unchanged.
- RECV, per vld beat:
  - data≠idx → bad=1, set flag[0].
  - idx increments by 1.
  - eof on a beat, len = idx+1:
    - len==EXP_LEN and bad=0 → frame_ok pulse next cycle, ok_cnt+1.
    - Otherwise → frame_err pulse, err_cnt+1; set flag[1] if len≠EXP_LEN.
    - In both cases last_len=len, return to IDLE.
  - Beat with idx==EXP_LEN and no eof (overrun) → set flag[1], frame_err pulse, err_cnt+1, last_len=EXP_LEN, enter DISCARD.
- DISCARD: beats ignored until a beat with eof → IDLE. A sof here restarts as from IDLE, with no extra error counted.
- sof while in RECV:
  - Current frame closes as error: flag[2], frame_err, err_cnt+1, last_len=idx.
  - New frame starts (idx=0). A vld in the same cycle is beat 0 of the new frame.
- Timer:
  - Increments each cycle in RECV or DISCARD.
  - Reaching TIMEOUT_CYC-1 in RECV → flag[4], frame_err, err_cnt+1, last_len=idx, IDLE.
  - Reaching it in DISCARD → IDLE only.
- Simultaneous events:
  - frame_ok and frame_err are never high in the same cycle.
  - clear wins over any same-cycle increment or flag set.
  - clear does not change state or idx.
- Saturation: counters hold at 0xFFFF; idx does not wrap, because overrun is caught at EXP_LEN.
- Reset mid-frame: returns to IDLE. Any remaining beats of that frame are then treated as orphans (flag[3]).

Optional Feature:
- UDP_RX_THROTTLE_EN defined:
  - Free-running 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 0x01 at reset).
  - ready = enable && ((lfsr & THR_MASK) != 0), i.e. pseudo-random back-pressure.
  - Acceptance rules are unchanged.
- Undefined: ready = enable; LFSR not built.

Test Plan:
- Clean frame: sof, then 32 beats 0x00..0x1F with eof on 0x1F → frame_ok one cycle after the eof beat, ok_cnt=1, last_len=32, err_flags=0.
- Corrupt byte: beat 5 = 0xFF → frame_err, err_cnt=1, flag[0]=1, ok_cnt=0.
- Short/long frames:
  - eof on beat 20 → flag[1], last_len=20.
  - 40 beats with eof on beat 40 → error raised at beat 33, DISCARD until eof, err_cnt=1.
- Protocol faults:
  - vld in IDLE → flag[3] only.
  - sof at beat 10 of a frame, followed by a clean frame → err_cnt=1, ok_cnt=1, flag[2].
- Timeout and clear:
  - sof plus 10 beats, then idle 1024 cycles → flag[4], frame_err once, busy=0.
  - Then clear → counters, flags and last_len = 0.
- Reset and back-pressure:
  - rst_n low at beat 15 → all outputs 0; trailing beats set flag[3].
  - With UDP_RX_THROTTLE_EN and the live source: 100 frames → ok_cnt=100, err_cnt=0.

Source files
------------

// File: rtl/udp_rx_check.sv
// Sink and checker for the bring-up byte stream: verifies incrementing payload and frame length,
// keeps saturating good/bad counters and sticky error flags. Define UDP_RX_THROTTLE_EN for LFSR back-pressure.
module udp_rx_check #(
    parameter int EXP_LEN     = 32,
    parameter int TIMEOUT_CYC = 1024,
    parameter int THR_MASK    = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clear,
    input  logic        sof,
    input  logic        vld,
    input  logic [7:0]  data,
    input  logic        eof,
    output logic        ready,
    output logic        busy,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] ok_cnt,
    output logic [15:0] err_cnt,
    output logic [4:0]  err_flags,
    output logic [7:0]  last_len
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_RECV = 2'd1;
    localparam logic [1:0]  S_DISC = 2'd2;

    localparam logic [7:0]  EXP_IDX      = 8'(EXP_LEN);
    localparam logic [8:0]  EXP_LEN9     = 9'(EXP_LEN);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    logic [1:0]  state, state_n;
    logic [7:0]  idx, idx_n, cur_idx;
    logic        bad, bad_n, cur_bad, beat_bad;
    logic [15:0] timer, timer_n;
    logic        do_beat, ok_ev, err_ev, len_upd;
    logic [4:0]  flag_set;
    logic [7:0]  len_val;
    logic [8:0]  len;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path infers a latch.
        state_n  = state;
        timer_n  = timer;
        ok_ev    = 1'b0;
        err_ev   = 1'b0;
        flag_set = '0;
        len_upd  = 1'b0;
        len_val  = last_len;
        do_beat  = 1'b0;
        cur_idx  = idx;
        cur_bad  = bad;
        beat_bad = 1'b0;
        len      = '0;

        case (state)
            S_IDLE: begin
                if (sof) begin
                    state_n = S_RECV;
                    cur_idx = '0;
                    cur_bad = 1'b0;
                    timer_n = '0;
                    do_beat = vld;
                end else if (vld) begin
                    flag_set[3] = 1'b1;
                end
            end
            S_RECV: begin
                timer_n = timer + 16'd1;
                if (sof) begin
                    flag_set[2] = 1'b1;
                    err_ev      = 1'b1;
                    len_upd     = 1'b1;
                    len_val     = idx;
                    cur_idx     = '0;
                    cur_bad     = 1'b0;
                    timer_n     = '0;
                end
                do_beat = vld;
            end
            S_DISC: begin
                timer_n = timer + 16'd1;
                if (sof) begin
                    state_n = S_RECV;
                    cur_idx = '0;
                    cur_bad = 1'b0;
                    timer_n = '0;
                    do_beat = vld;
                end else if ((vld && eof) || timer == TIMEOUT_LAST) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        idx_n = cur_idx;
        bad_n = cur_bad;

        if (do_beat) begin
            beat_bad = cur_bad | (data != cur_idx);
            bad_n    = beat_bad;
            if (data != cur_idx) flag_set[0] = 1'b1;
            if (eof) begin
                len     = {1'b0, cur_idx} + 9'd1;
                state_n = S_IDLE;
                len_upd = 1'b1;
                len_val = len[8] ? 8'hFF : len[7:0];
                if (len != EXP_LEN9) flag_set[1] = 1'b1;
                // A same-cycle abort of the previous frame already claims this cycle's pulse.
                if (len == EXP_LEN9 && !beat_bad && !err_ev) ok_ev = 1'b1;
                else err_ev = 1'b1;
            end else if (cur_idx == EXP_IDX) begin
                flag_set[1] = 1'b1;
                err_ev      = 1'b1;
                len_upd     = 1'b1;
                len_val     = EXP_IDX;
                state_n     = S_DISC;
            end else begin
                idx_n = cur_idx + 8'd1;
            end
        end

        if (state == S_RECV && !sof && state_n == S_RECV && timer == TIMEOUT_LAST) begin
            flag_set[4] = 1'b1;
            err_ev      = 1'b1;
            len_upd     = 1'b1;
            len_val     = idx_n;
            state_n     = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            bad       <= 1'b0;
            timer     <= '0;
            busy      <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            ok_cnt    <= '0;
            err_cnt   <= '0;
            err_flags <= '0;
            last_len  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state     <= state_n;
            idx       <= idx_n;
            bad       <= bad_n;
            timer     <= timer_n;
            busy      <= (state_n != S_IDLE);
            frame_ok  <= ok_ev;
            frame_err <= err_ev;
            if (clear) begin
                ok_cnt    <= '0;
                err_cnt   <= '0;
                err_flags <= '0;
                last_len  <= '0;
            end else begin
                if (ok_ev && ok_cnt != 16'hFFFF)   ok_cnt  <= ok_cnt + 16'd1;
                if (err_ev && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                err_flags <= err_flags | flag_set;
                if (len_upd) last_len <= len_val;
            end
        end
    end

`ifdef UDP_RX_THROTTLE_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr  <= 8'h01;
            ready <= 1'b0;
        end else begin
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            ready <= enable && ((lfsr & 8'(THR_MASK)) != 8'h00);
        end
    end
`else
    logic unused_thr_mask;
    assign unused_thr_mask = ^8'(THR_MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready <= 1'b0;
        else        ready <= enable;
    end
`endif

endmodule

// File: tb/tb_udp_rx_check.sv
// Self-checking bench for udp_rx_check: directed scenarios plus randomized frames against a frame-level model.
module tb_udp_rx_check;

    localparam int EXP_LEN     = 32;
    localparam int TIMEOUT_CYC = 1024;

    logic        clk = 1'b0;
    logic        rst_n, enable, clear, sof, vld, eof;
    logic [7:0]  data;
    logic        ready, busy, frame_ok, frame_err;
    logic [15:0] ok_cnt, err_cnt;
    logic [4:0]  err_flags;
    logic [7:0]  last_len;

    int n_cmp = 0;
    int n_bad = 0;
    int ok_seen = 0;
    int err_seen = 0;
    logic rdy_s = 1'b0;

    udp_rx_check #(.EXP_LEN(EXP_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .THR_MASK(7)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .sof(sof), .vld(vld), .data(data), .eof(eof),
        .ready(ready), .busy(busy), .frame_ok(frame_ok), .frame_err(frame_err),
        .ok_cnt(ok_cnt), .err_cnt(err_cnt), .err_flags(err_flags), .last_len(last_len)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        rdy_s = ready;
        if (frame_ok)  ok_seen++;
        if (frame_err) err_seen++;
        if (frame_ok || frame_err) begin
            n_cmp++;
            if (frame_ok && frame_err) begin
                n_bad++;
                $display("FAIL pulse_exclusive: frame_ok and frame_err both high at %0t", $time);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        sof = 1'b0; vld = 1'b0; eof = 1'b0; data = 8'h00; clear = 1'b0;
    endtask

    task automatic beat(input logic s, input logic [7:0] d, input logic e);
        sof = s; vld = 1'b1; data = d; eof = e;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Sends len beats; beat bad_at (if >= 0) has its byte XORed with bad_xor.
    task automatic send_frame(input int len, input int bad_at, input logic [7:0] bad_xor,
                              input bit sof_first, input int gap_max);
        if (!sof_first) begin
            sof = 1'b1;
            step();
        end
        for (int i = 0; i < len; i++) begin
            if (!(sof_first && i == 0)) repeat ($urandom_range(gap_max, 0)) step();
            beat(sof_first && i == 0, (i == bad_at) ? (8'(i) ^ bad_xor) : 8'(i), i == len - 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ready, busy, frame_ok, frame_err, ok_cnt, err_cnt, err_flags, last_len} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ok=%0d err=%0d flags=%b len=%0d busy=%b ready=%b want all 0",
                     ok_cnt, err_cnt, err_flags, last_len, busy, ready);
        end
        rst_n = 1'b1; enable = 1'b1;
        step();
    endtask

    task automatic test_clean();
        do_reset();
        send_frame(EXP_LEN, -1, 8'h00, 1'b0, 0);
        n_cmp++;
        if (frame_ok !== 1'b1 || frame_err !== 1'b0) begin
            n_bad++; $display("FAIL clean_pulse: got ok=%b err=%b want 1/0", frame_ok, frame_err);
        end
        n_cmp++;
        if (ok_cnt !== 16'd1 || err_cnt !== 16'd0 || last_len !== 8'd32 || err_flags !== 5'd0) begin
            n_bad++; $display("FAIL clean_status: got ok=%0d err=%0d len=%0d flags=%b want 1/0/32/0",
                              ok_cnt, err_cnt, last_len, err_flags);
        end
        step();
        n_cmp++;
        if (frame_ok !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL clean_one_cycle: got ok=%b busy=%b want 0/0", frame_ok, busy);
        end
    endtask

    task automatic test_corrupt();
        do_reset();
        sof = 1'b1;
        step();
        for (int i = 0; i < EXP_LEN; i++) beat(1'b0, (i == 5) ? 8'hFF : 8'(i), i == EXP_LEN - 1);
        n_cmp++;
        if (frame_err !== 1'b1 || err_cnt !== 16'd1 || ok_cnt !== 16'd0 || err_flags !== 5'b00001) begin
            n_bad++; $display("FAIL corrupt: got pulse=%b err=%0d ok=%0d flags=%b want 1/1/0/00001",
                              frame_err, err_cnt, ok_cnt, err_flags);
        end
    endtask

    task automatic test_short_long();
        do_reset();
        send_frame(20, -1, 8'h00, 1'b0, 0);
        n_cmp++;
        if (err_flags !== 5'b00010 || last_len !== 8'd20 || err_cnt !== 16'd1) begin
            n_bad++; $display("FAIL short: got flags=%b len=%0d err=%0d want 00010/20/1", err_flags, last_len, err_cnt);
        end
        do_reset();
        sof = 1'b1;
        step();
        for (int i = 0; i < 40; i++) begin
            beat(1'b0, 8'(i), i == 39);
            if (i == EXP_LEN) begin
                n_cmp++;
                if (frame_err !== 1'b1 || busy !== 1'b1 || last_len !== 8'd32) begin
                    n_bad++; $display("FAIL long_overrun: got pulse=%b busy=%b len=%0d want 1/1/32",
                                      frame_err, busy, last_len);
                end
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || err_cnt !== 16'd1 || err_flags !== 5'b00010 || frame_err !== 1'b0) begin
            n_bad++; $display("FAIL long_end: got busy=%b err=%0d flags=%b pulse=%b want 0/1/00010/0",
                              busy, err_cnt, err_flags, frame_err);
        end
    endtask

    task automatic test_protocol();
        do_reset();
        beat(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (err_flags !== 5'b01000 || ok_cnt !== 16'd0 || err_cnt !== 16'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL orphan: got flags=%b ok=%0d err=%0d busy=%b want 01000/0/0/0",
                              err_flags, ok_cnt, err_cnt, busy);
        end
        do_reset();
        sof = 1'b1;
        step();
        for (int i = 0; i < 10; i++) beat(1'b0, 8'(i), 1'b0);
        beat(1'b1, 8'h00, 1'b0);
        n_cmp++;
        if (frame_err !== 1'b1 || last_len !== 8'd10 || err_flags !== 5'b00100) begin
            n_bad++; $display("FAIL sof_abort: got pulse=%b len=%0d flags=%b want 1/10/00100",
                              frame_err, last_len, err_flags);
        end
        for (int i = 1; i < EXP_LEN; i++) beat(1'b0, 8'(i), i == EXP_LEN - 1);
        n_cmp++;
        if (err_cnt !== 16'd1 || ok_cnt !== 16'd1 || last_len !== 8'd32 || err_flags !== 5'b00100) begin
            n_bad++; $display("FAIL sof_restart: got err=%0d ok=%0d len=%0d flags=%b want 1/1/32/00100",
                              err_cnt, ok_cnt, last_len, err_flags);
        end
    endtask

    task automatic test_timeout_clear();
        int e0;
        do_reset();
        sof = 1'b1;
        step();
        for (int i = 0; i < 10; i++) beat(1'b0, 8'(i), 1'b0);
        e0 = err_seen;
        repeat (TIMEOUT_CYC) step();
        n_cmp++;
        if (err_seen - e0 !== 1 || err_flags !== 5'b10000 || busy !== 1'b0 || last_len !== 8'd10 || err_cnt !== 16'd1) begin
            n_bad++; $display("FAIL timeout: got pulses=%0d flags=%b busy=%b len=%0d err=%0d want 1/10000/0/10/1",
                              err_seen - e0, err_flags, busy, last_len, err_cnt);
        end
        clear = 1'b1;
        step();
        n_cmp++;
        if (ok_cnt !== 16'd0 || err_cnt !== 16'd0 || err_flags !== 5'd0 || last_len !== 8'd0) begin
            n_bad++; $display("FAIL clear: got ok=%0d err=%0d flags=%b len=%0d want all 0",
                              ok_cnt, err_cnt, err_flags, last_len);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sof = 1'b1;
        step();
        for (int i = 0; i < 15; i++) beat(1'b0, 8'(i), 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ready, busy, frame_ok, frame_err, ok_cnt, err_cnt, err_flags, last_len} !== '0) begin
            n_bad++; $display("FAIL reset_mid_outputs: got busy=%b ready=%b flags=%b want all 0", busy, ready, err_flags);
        end
        step();
        rst_n = 1'b1;
        for (int i = 15; i < EXP_LEN; i++) beat(1'b0, 8'(i), i == EXP_LEN - 1);
        step();
        n_cmp++;
        if (err_flags !== 5'b01000 || ok_cnt !== 16'd0 || err_cnt !== 16'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_orphans: got flags=%b ok=%0d err=%0d busy=%b want 01000/0/0/0",
                              err_flags, ok_cnt, err_cnt, busy);
        end
    endtask

    // Randomized frames; the model derives each frame's verdict from its length and corrupt position.
    task automatic test_random();
        int exp_ok = 0, exp_err = 0, exp_last = 0;
        logic [4:0] exp_flags = '0;
        int o0, e0, len, bad_at, sel;
        do_reset();
        o0 = ok_seen; e0 = err_seen;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(4, 0) == 0) begin
                beat(1'b0, 8'($urandom_range(255, 0)), $urandom_range(1, 0) == 1);
                exp_flags[3] = 1'b1;
            end
            sel = $urandom_range(3, 0);
            len = (sel < 2) ? EXP_LEN : (sel == 2) ? $urandom_range(EXP_LEN - 1, 1)
                                                    : $urandom_range(EXP_LEN + 8, EXP_LEN + 1);
            bad_at = ($urandom_range(3, 0) == 0) ? $urandom_range(len - 1, 0) : -1;
            send_frame(len, bad_at, 8'($urandom_range(255, 1)), $urandom_range(1, 0) == 1, 2);
            if (len == EXP_LEN && bad_at < 0) exp_ok++;
            else exp_err++;
            if (bad_at >= 0 && bad_at <= EXP_LEN) exp_flags[0] = 1'b1;
            if (len != EXP_LEN) exp_flags[1] = 1'b1;
            exp_last = (len > EXP_LEN) ? EXP_LEN : len;
            step();
            n_cmp++;
            if (last_len !== 8'(exp_last)) begin
                n_bad++; $display("FAIL rand_last_len frame %0d: got %0d want %0d", f, last_len, exp_last);
            end
        end
        n_cmp++;
        if (ok_cnt !== 16'(exp_ok) || err_cnt !== 16'(exp_err) || err_flags !== exp_flags) begin
            n_bad++; $display("FAIL rand_totals: got ok=%0d err=%0d flags=%b want %0d/%0d/%b",
                              ok_cnt, err_cnt, err_flags, exp_ok, exp_err, exp_flags);
        end
        n_cmp++;
        if (ok_seen - o0 !== exp_ok || err_seen - e0 !== exp_err || busy !== 1'b0) begin
            n_bad++; $display("FAIL rand_pulses: got ok=%0d err=%0d busy=%b want %0d/%0d/0",
                              ok_seen - o0, err_seen - e0, busy, exp_ok, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        int o0;
        do_reset();
        o0 = ok_seen;
        for (int f = 0; f < 5; f++) send_frame(EXP_LEN, -1, 8'h00, 1'b1, 0);
        step();
        n_cmp++;
        if (ok_cnt !== 16'd5 || err_cnt !== 16'd0 || ok_seen - o0 !== 5 || err_flags !== 5'd0) begin
            n_bad++; $display("FAIL back_to_back: got ok=%0d err=%0d pulses=%0d flags=%b want 5/0/5/0",
                              ok_cnt, err_cnt, ok_seen - o0, err_flags);
        end
    endtask

    // Live source: launches a beat only in the cycle after it saw ready high.
    task automatic test_back_pressure();
        int n_frames, budget;
        logic e;
        bit timed_out = 1'b0;
`ifdef UDP_RX_THROTTLE_EN
        n_frames = 100;
`else
        n_frames = 20;
`endif
        do_reset();
        for (int f = 0; f < n_frames && !timed_out; f++) begin
            for (int i = 0; i < EXP_LEN && !timed_out; i++) begin
                budget = 0;
                while (!rdy_s && !timed_out) begin
                    enable = ($urandom_range(3, 0) != 0);
                    step();
                    budget++;
                    if (budget > 200) timed_out = 1'b1;
                end
                e = enable;
                sof = (i == 0); vld = 1'b1; data = 8'(i); eof = (i == EXP_LEN - 1);
                enable = ($urandom_range(3, 0) != 0);
                e = enable;
                step();
`ifndef UDP_RX_THROTTLE_EN
                n_cmp++;
                if (ready !== e) begin
                    n_bad++; $display("FAIL ready_follows_enable: got %b want %b", ready, e);
                end
`endif
            end
        end
        enable = 1'b1;
        n_cmp++;
        if (timed_out) begin
            n_bad++; $display("FAIL bp_ready_timeout: ready stayed low beyond 200 cycles");
        end
        step();
        n_cmp++;
        if (ok_cnt !== 16'(n_frames) || err_cnt !== 16'd0) begin
            n_bad++; $display("FAIL back_pressure: got ok=%0d err=%0d want %0d/0", ok_cnt, err_cnt, n_frames);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
        sof = 1'b0; vld = 1'b0; eof = 1'b0; data = 8'h00;
        test_reset();
        test_clean();
        test_corrupt();
        test_short_long();
        test_protocol();
        test_timeout_clear();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_back_pressure();
        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
